// File: rtl/ctrl_pipe.sv
// Pipeline control register chain (E/M/W) with load-use and branch hazard
// handling, plus a stop/drain/halt sequencer that retires in-flight work.
module ctrl_pipe (
  input  logic       clk,
  input  logic       reset,
  input  logic       RegWriteEN_D,
  input  logic       Mem2RegSEL_D,
  input  logic       MemWriteEN_D,
  input  logic       Branch_D,
  input  logic       RegDst_D,
  input  logic [3:0] ALUCtrl_D,
  input  logic [2:0] ALUSrc_D,
  input  logic       Stop_D,
  input  logic [4:0] Rs_D,
  input  logic [4:0] Rt_D,
  input  logic [4:0] Rd_D,
  input  logic       BranchTaken_M,
  output logic       RegWriteEN_E,
  output logic       Mem2RegSEL_E,
  output logic       MemWriteEN_E,
  output logic       Branch_E,
  output logic [3:0] ALUCtrl_E,
  output logic [2:0] ALUSrc_E,
  output logic [4:0] WriteReg_E,
  output logic       RegWriteEN_M,
  output logic       Mem2RegSEL_M,
  output logic       MemWriteEN_M,
  output logic       Branch_M,
  output logic [4:0] WriteReg_M,
  output logic       RegWriteEN_W,
  output logic       Mem2RegSEL_W,
  output logic [4:0] WriteReg_W,
  output logic       Stall_F,
  output logic       Stall_D,
  output logic       Flush_D,
  output logic       Halt
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  typedef struct packed {
    logic       rw;
    logic       m2r;
    logic       mw;
    logic       br;
    logic [3:0] alu;
    logic [2:0] src;
    logic [4:0] wr;
  } e_ctrl_t;

  typedef struct packed {
    logic       rw;
    logic       m2r;
    logic       mw;
    logic       br;
    logic [4:0] wr;
  } m_ctrl_t;

  typedef struct packed {
    logic       rw;
    logic       m2r;
    logic [4:0] wr;
  } w_ctrl_t;

  state_t  r_state, w_state_nxt;
  logic [1:0] r_cnt, w_cnt_nxt;
  e_ctrl_t r_e, w_e_nxt;
  m_ctrl_t r_m;
  w_ctrl_t r_w;
  logic    r_stop_e, w_stop_e_nxt;
  logic    w_load_use, w_cancel, w_capture, w_stall, w_flush;

  assign w_load_use = r_e.m2r & r_e.rw & (r_e.wr != 5'd0) &
                      ((r_e.wr == Rs_D) | (r_e.wr == Rt_D));

  // A taken branch one stage ahead of a freshly captured stop squashes it.
  assign w_cancel = (r_state == ST_DRAIN) && (r_cnt == 2'd2) && r_stop_e && BranchTaken_M;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state <= ST_RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_capture && Stop_D) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = 2'd2;
        end
      end
      ST_DRAIN: begin
        if (w_cancel) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = 2'd0;
        end else if (r_cnt == 2'd0) begin
          w_state_nxt = ST_HALTED;
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
        end
      end
      ST_HALTED: w_cnt_nxt = 2'd0;
      default: begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = 2'd0;
      end
    endcase
  end

  // Output / hazard decode
  always_comb begin
    w_stall   = 1'b0;
    w_flush   = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_flush   = BranchTaken_M;
        w_stall   = w_load_use & ~BranchTaken_M;
        w_capture = ~w_load_use & ~BranchTaken_M;
      end
      ST_DRAIN: begin
        if (w_cancel) w_flush = 1'b1;
        else          w_stall = 1'b1;
      end
      ST_HALTED: w_stall = 1'b1;
      default: ;
    endcase
  end

  // The stop instruction enters E as a bubble that only carries the stop bit.
  always_comb begin
    w_e_nxt      = '0;
    w_stop_e_nxt = w_capture & Stop_D;
    if (w_capture && !Stop_D) begin
      w_e_nxt.rw  = RegWriteEN_D;
      w_e_nxt.m2r = Mem2RegSEL_D;
      w_e_nxt.mw  = MemWriteEN_D;
      w_e_nxt.br  = Branch_D;
      w_e_nxt.alu = ALUCtrl_D;
      w_e_nxt.src = ALUSrc_D;
      w_e_nxt.wr  = RegDst_D ? Rd_D : Rt_D;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_e      <= '0;
      r_stop_e <= 1'b0;
      r_m      <= '0;
      r_w      <= '0;
    end else begin
      r_e      <= w_e_nxt;
      r_stop_e <= w_stop_e_nxt;
      r_m      <= '{rw: r_e.rw, m2r: r_e.m2r, mw: r_e.mw, br: r_e.br, wr: r_e.wr};
      r_w      <= '{rw: r_m.rw, m2r: r_m.m2r, wr: r_m.wr};
    end
  end

  assign RegWriteEN_E = r_e.rw;
  assign Mem2RegSEL_E = r_e.m2r;
  assign MemWriteEN_E = r_e.mw;
  assign Branch_E     = r_e.br;
  assign ALUCtrl_E    = r_e.alu;
  assign ALUSrc_E     = r_e.src;
  assign WriteReg_E   = r_e.wr;
  assign RegWriteEN_M = r_m.rw;
  assign Mem2RegSEL_M = r_m.m2r;
  assign MemWriteEN_M = r_m.mw;
  assign Branch_M     = r_m.br;
  assign WriteReg_M   = r_m.wr;
  assign RegWriteEN_W = r_w.rw;
  assign Mem2RegSEL_W = r_w.m2r;
  assign WriteReg_W   = r_w.wr;

  assign Stall_F = w_stall & ~reset;
  assign Stall_D = w_stall & ~reset;
  assign Flush_D = w_flush & ~reset;
  assign Halt    = (r_state == ST_HALTED);

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: each driven instruction queues its expected
// E/M/W images and hazard outputs; a negedge monitor pops and compares them.
module tb_ctrl_pipe;

  typedef struct packed {
    logic       rw, m2r, mw, br, rdst;
    logic [3:0] alu;
    logic [2:0] src;
    logic       stop;
    logic [4:0] rs, rt, rd;
  } ins_t;

  typedef struct {
    int          cyc;
    logic [15:0] v;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  logic RegWriteEN_D, Mem2RegSEL_D, MemWriteEN_D, Branch_D, RegDst_D;
  logic [3:0] ALUCtrl_D;
  logic [2:0] ALUSrc_D;
  logic Stop_D;
  logic [4:0] Rs_D, Rt_D, Rd_D;
  logic BranchTaken_M;
  logic RegWriteEN_E, Mem2RegSEL_E, MemWriteEN_E, Branch_E;
  logic [3:0] ALUCtrl_E;
  logic [2:0] ALUSrc_E;
  logic [4:0] WriteReg_E;
  logic RegWriteEN_M, Mem2RegSEL_M, MemWriteEN_M, Branch_M;
  logic [4:0] WriteReg_M;
  logic RegWriteEN_W, Mem2RegSEL_W;
  logic [4:0] WriteReg_W;
  logic Stall_F, Stall_D, Flush_D, Halt;

  ctrl_pipe dut (
    .clk(clk), .reset(reset),
    .RegWriteEN_D(RegWriteEN_D), .Mem2RegSEL_D(Mem2RegSEL_D),
    .MemWriteEN_D(MemWriteEN_D), .Branch_D(Branch_D), .RegDst_D(RegDst_D),
    .ALUCtrl_D(ALUCtrl_D), .ALUSrc_D(ALUSrc_D), .Stop_D(Stop_D),
    .Rs_D(Rs_D), .Rt_D(Rt_D), .Rd_D(Rd_D), .BranchTaken_M(BranchTaken_M),
    .RegWriteEN_E(RegWriteEN_E), .Mem2RegSEL_E(Mem2RegSEL_E),
    .MemWriteEN_E(MemWriteEN_E), .Branch_E(Branch_E),
    .ALUCtrl_E(ALUCtrl_E), .ALUSrc_E(ALUSrc_E), .WriteReg_E(WriteReg_E),
    .RegWriteEN_M(RegWriteEN_M), .Mem2RegSEL_M(Mem2RegSEL_M),
    .MemWriteEN_M(MemWriteEN_M), .Branch_M(Branch_M), .WriteReg_M(WriteReg_M),
    .RegWriteEN_W(RegWriteEN_W), .Mem2RegSEL_W(Mem2RegSEL_W), .WriteReg_W(WriteReg_W),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_D(Flush_D), .Halt(Halt)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  logic mon_en = 1'b0;
  ent_t q_e[$], q_m[$], q_w[$], q_h[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic ins_t mk(input logic rw, m2r, mw, br, rdst, input logic [3:0] alu,
                              input logic [2:0] src, input logic stop,
                              input logic [4:0] rs, rt, rd);
    ins_t i;
    i = '{rw: rw, m2r: m2r, mw: mw, br: br, rdst: rdst, alu: alu, src: src,
          stop: stop, rs: rs, rt: rt, rd: rd};
    return i;
  endfunction

  function automatic ins_t nop();                        return mk(0,0,0,0,0,4'd0,3'd0,0,5'd0,5'd0,5'd0); endfunction
  function automatic ins_t add(input logic [4:0] s, t, d); return mk(1,0,0,0,1,4'd0,3'd0,0,s,t,d);          endfunction
  function automatic ins_t lw(input logic [4:0] s, t);     return mk(1,1,0,0,0,4'd0,3'd1,0,s,t,5'd0);       endfunction
  function automatic ins_t sw(input logic [4:0] s, t);     return mk(0,0,1,0,0,4'd0,3'd1,0,s,t,5'd0);       endfunction
  function automatic ins_t beq(input logic [4:0] s, t);    return mk(0,0,0,1,0,4'd1,3'd0,0,s,t,5'd0);       endfunction
  // Stop opcode with deliberately non-zero control fields: E must still see a bubble.
  function automatic ins_t stp(input logic [4:0] s);       return mk(1,0,1,0,1,4'd9,3'd4,1,s,s,5'd9);       endfunction

  task automatic apply(input ins_t i, input logic bt);
    RegWriteEN_D = i.rw;  Mem2RegSEL_D = i.m2r; MemWriteEN_D = i.mw;
    Branch_D     = i.br;  RegDst_D     = i.rdst;
    ALUCtrl_D    = i.alu; ALUSrc_D     = i.src; Stop_D = i.stop;
    Rs_D = i.rs; Rt_D = i.rt; Rd_D = i.rd;
    BranchTaken_M = bt;
  endtask

  // Drive one D-stage instruction for a cycle, stating whether E takes it and
  // what Stall/Flush/Halt must read during this cycle.
  task automatic drive(input ins_t i, input logic bt, input logic capt,
                       input logic stall, input logic flush, input logic halt);
    logic [4:0] wr;
    apply(i, bt);
    q_h.push_back('{cyc: cyc, v: {12'd0, stall, stall, flush, halt}});
    if (capt && !i.stop) begin
      wr = i.rdst ? i.rd : i.rt;
      q_e.push_back('{cyc: cyc + 1, v: {i.rw, i.m2r, i.mw, i.br, i.alu, i.src, wr}});
      q_m.push_back('{cyc: cyc + 2, v: {7'd0, i.rw, i.m2r, i.mw, i.br, wr}});
      q_w.push_back('{cyc: cyc + 3, v: {9'd0, i.rw, i.m2r, wr}});
    end
    @(posedge clk); #1;
  endtask

  // One reset cycle with hostile inputs; everything due later is discarded.
  task automatic do_reset(input logic halt);
    reset = 1'b1;
    apply(stp(5'd8), 1'b1);
    q_h.push_back('{cyc: cyc, v: {12'd0, 1'b0, 1'b0, 1'b0, halt}});
    while (q_e.size() > 0 && q_e[$].cyc > cyc) void'(q_e.pop_back());
    while (q_m.size() > 0 && q_m[$].cyc > cyc) void'(q_m.pop_back());
    while (q_w.size() > 0 && q_w[$].cyc > cyc) void'(q_w.pop_back());
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    ent_t        t;
    logic [15:0] ee, em, ew;
    if (mon_en) begin
      ee = '0; em = '0; ew = '0;
      if (q_e.size() > 0 && q_e[0].cyc == cyc) begin t = q_e.pop_front(); ee = t.v; end
      if (q_m.size() > 0 && q_m[0].cyc == cyc) begin t = q_m.pop_front(); em = t.v; end
      if (q_w.size() > 0 && q_w[0].cyc == cyc) begin t = q_w.pop_front(); ew = t.v; end
      check("E_stage", {RegWriteEN_E, Mem2RegSEL_E, MemWriteEN_E, Branch_E,
                        ALUCtrl_E, ALUSrc_E, WriteReg_E}, ee);
      check("M_stage", {7'd0, RegWriteEN_M, Mem2RegSEL_M, MemWriteEN_M, Branch_M, WriteReg_M}, em);
      check("W_stage", {9'd0, RegWriteEN_W, Mem2RegSEL_W, WriteReg_W}, ew);
      if (q_h.size() > 0 && q_h[0].cyc == cyc) begin
        t = q_h.pop_front();
        check("hazard", {12'd0, Stall_F, Stall_D, Flush_D, Halt}, t.v);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    apply(stp(5'd8), 1'b1);
    @(posedge clk); #1;
    mon_en = 1'b1;
    do_reset(1'b0);

    // ADD r5 walks E -> M -> W
    drive(add(5'd1, 5'd2, 5'd5), 0, 1, 0, 0, 0);
    repeat (3) drive(nop(), 0, 1, 0, 0, 0);

    // Load-use on Rs, then the WriteReg==0 exemption, then load-use on Rt
    drive(lw(5'd1, 5'd8),         0, 1, 0, 0, 0);
    drive(add(5'd8, 5'd2, 5'd9),  0, 0, 1, 0, 0);
    drive(add(5'd8, 5'd2, 5'd9),  0, 1, 0, 0, 0);
    drive(lw(5'd3, 5'd0),         0, 1, 0, 0, 0);
    drive(add(5'd0, 5'd0, 5'd3),  0, 1, 0, 0, 0);
    drive(lw(5'd1, 5'd7),         0, 1, 0, 0, 0);
    drive(sw(5'd2, 5'd7),         0, 0, 1, 0, 0);
    drive(sw(5'd2, 5'd7),         0, 1, 0, 0, 0);
    drive(nop(),                  0, 1, 0, 0, 0);

    // Branch beats load-use; branch alone flushes
    drive(lw(5'd1, 5'd8),         0, 1, 0, 0, 0);
    drive(add(5'd8, 5'd2, 5'd9),  1, 0, 0, 1, 0);
    drive(nop(),                  0, 1, 0, 0, 0);
    drive(add(5'd1, 5'd2, 5'd4),  1, 0, 0, 1, 0);
    drive(nop(),                  0, 1, 0, 0, 0);

    // Stop held off by a load-use stall must not start a drain
    drive(lw(5'd1, 5'd4),         0, 1, 0, 0, 0);
    drive(stp(5'd4),              0, 0, 1, 0, 0);
    drive(add(5'd1, 5'd2, 5'd11), 0, 1, 0, 0, 0);
    drive(nop(),                  0, 1, 0, 0, 0);

    // Full stop: three drain cycles, then halted; the ADD retires first
    drive(add(5'd1, 5'd2, 5'd12), 0, 1, 0, 0, 0);
    drive(stp(5'd0),              0, 1, 0, 0, 0);
    drive(lw(5'd12, 5'd12),       0, 0, 1, 0, 0);
    drive(add(5'd1, 5'd1, 5'd1),  0, 0, 1, 0, 0);
    drive(nop(),                  0, 0, 1, 0, 0);
    drive(add(5'd3, 5'd3, 5'd3),  1, 0, 1, 0, 1);
    drive(nop(),                  0, 0, 1, 0, 1);
    do_reset(1'b1);
    drive(add(5'd1, 5'd2, 5'd13), 0, 1, 0, 0, 0);

    // Stop in E cancelled by a taken branch in M
    drive(beq(5'd1, 5'd2),        0, 1, 0, 0, 0);
    drive(stp(5'd0),              0, 1, 0, 0, 0);
    drive(add(5'd1, 5'd2, 5'd14), 1, 0, 0, 1, 0);
    drive(add(5'd1, 5'd2, 5'd6),  0, 1, 0, 0, 0);
    repeat (4) drive(nop(), 0, 1, 0, 0, 0);

    // Reset in the middle of a drain returns to RUN
    drive(stp(5'd0),              0, 1, 0, 0, 0);
    drive(nop(),                  0, 0, 1, 0, 0);
    do_reset(1'b0);
    drive(add(5'd2, 5'd3, 5'd15), 0, 1, 0, 0, 0);
    repeat (4) drive(nop(), 0, 1, 0, 0, 0);

    repeat (4) @(posedge clk);
    #1;
    mon_en = 1'b0;
    check("q_left", 16'(q_e.size() + q_m.size() + q_w.size() + q_h.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have inputs RegWriteEN_D, Mem2RegSEL_D, MemWriteEN_D, Branch_D, RegDst_D  input  1 each  decode-stage control bits from the main control decoder.
REQ-004 SHALL have inputs ALUCtrl_D  input  4  ALU operation code (0..9), and ALUSrc_D  input  3  operand-select code (0..4).
REQ-005 SHALL have inputs Stop_D  input  1  decoded opcode 6'd63; Rs_D, Rt_D, Rd_D  input  5 each  register fields.
REQ-006 SHALL have input BranchTaken_M  input  1  branch in M resolved taken.
REQ-007 SHALL have E outputs RegWriteEN_E, Mem2RegSEL_E, MemWriteEN_E, Branch_E, ALUCtrl_E[3:0], ALUSrc_E[2:0], WriteReg_E[4:0].
REQ-008 SHALL have M outputs RegWriteEN_M, Mem2RegSEL_M, MemWriteEN_M, Branch_M, WriteReg_M[4:0]; W outputs RegWriteEN_W, Mem2RegSEL_W, WriteReg_W[4:0].
REQ-009 SHALL have outputs Stall_F, Stall_D, Flush_D  output  1 each, and Halt  output  1  pipeline stopped.

Function
REQ-010 Bubble SHALL mean all control bits, ALUCtrl, ALUSrc and WriteReg equal 0, Stop bit 0.
REQ-011 E register SHALL capture D inputs each cycle, with WriteReg_E = RegDst_D ? Rd_D : Rt_D, unless a bubble is inserted.
REQ-012 M and W registers SHALL advance unconditionally every cycle (never stall); latency D->E 1, E->M 1, M->W 1.
REQ-013 LoadUse SHALL = Mem2RegSEL_E & RegWriteEN_E & (WriteReg_E != 0) & (WriteReg_E == Rs_D | WriteReg_E == Rt_D), combinational.
REQ-014 On LoadUse without BranchTaken_M: Stall_F=1, Stall_D=1, next E = bubble.
REQ-015 On BranchTaken_M: Flush_D=1, next E = bubble, Stall_F=Stall_D=0 (branch overrides LoadUse).
REQ-016 Internal Stop_E bit SHALL travel with E; FSM states RUN, DRAIN, HALTED; counter cnt[1:0].
REQ-017 RUN->DRAIN when Stop_D is captured into E (no stall, no flush); cnt loaded with 2.
REQ-018 In DRAIN: Stall_F=Stall_D=1, E captures bubbles, cnt decrements each cycle; DRAIN->HALTED when cnt==0.
REQ-019 In DRAIN with cnt==2 and BranchTaken_M=1: stop cancelled, Stop_E cleared, E bubble, return to RUN, Flush_D=1, Stall_F=Stall_D=0.
REQ-020 In HALTED: Halt=1, Stall_F=Stall_D=1, all E/M/W outputs bubble, held until reset; inputs ignored.
REQ-021 Halt SHALL be 0 in RUN and DRAIN; a Stop_D arriving during a LoadUse stall SHALL NOT start DRAIN until captured.
REQ-022 Stop instruction itself SHALL carry bubble controls (no register or memory write).

Reset
REQ-023 With reset=1 at a clock edge, all E/M/W registers SHALL become bubble, FSM=RUN, cnt=0, Halt=0.
REQ-024 Stall_F, Stall_D, Flush_D SHALL be 0 during reset cycles regardless of inputs; reset mid-DRAIN or in HALTED SHALL return to RUN next cycle.

Verification
REQ-025 ADD: RegWriteEN_D=1, RegDst_D=1, ALUCtrl_D=0, Rd_D=5 -> E shows WriteReg_E=5 at cycle+1, RegWriteEN_M=1 at +2, RegWriteEN_W=1, WriteReg_W=5 at +3.
REQ-026 LW to Rt=8 in E (Mem2RegSEL_E=1, RegWriteEN_E=1), Rs_D=8 -> Stall_F=Stall_D=1 one cycle, E bubble next cycle, D instruction enters E the cycle after; WriteReg_E=0 case with Rs_D=0 -> no stall.
REQ-027 LoadUse and BranchTaken_M=1 same cycle -> Flush_D=1, Stall_D=0, E bubble.
REQ-028 Stop_D=1 in RUN -> DRAIN for 3 cycles with stalls, Halt=1 on fourth cycle and thereafter; ADD preceding stop reaches W before Halt.
REQ-029 Stop in E with BranchTaken_M=1 -> Halt stays 0, FSM RUN, Flush_D=1; reset asserted in HALTED -> Halt=0, all outputs 0 next cycle.
